// File: rtl/operand_select_reg_pkg.sv
// Shared definitions for the registered operand selector.
//   ARB_FIXED / ARB_RR : encodings of the arb_mode input
//   buf_state_t        : occupancy of the 2-entry output buffer
package operand_select_reg_pkg;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/operand_select_reg_skid.sv
// skid_buffer2: 2-entry valid/ready FIFO (head + skid register).
//   clk, rst_n  : clock, async active-low reset
//   push        : write push_data this cycle (caller guarantees !full)
//   push_data   : entry to store
//   full        : both entries occupied
//   pop_ready   : downstream ready; pops when out_valid is high
//   out_valid   : head entry is valid
//   out_data    : head entry, registered; holds its last value when empty
//
// state     | meaning
// BUF_EMPTY | no entries, out_valid low
// BUF_ONE   | head holds the only entry
// BUF_FULL  | head holds the oldest entry, skid holds the next one
module skid_buffer2
    import operand_select_reg_pkg::*;
#(
    parameter int DW = 34
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          full,
    input  logic          pop_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    buf_state_t    r_state;
    buf_state_t    w_next_state;
    logic [DW-1:0] r_head;
    logic [DW-1:0] r_skid;
    logic          w_pop;

    assign w_pop     = (r_state != BUF_EMPTY) && pop_ready;
    assign out_valid = (r_state != BUF_EMPTY);
    assign full      = (r_state == BUF_FULL);
    assign out_data  = r_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            BUF_EMPTY: if (push) w_next_state = BUF_ONE;
            BUF_ONE: begin
                if (push && !w_pop)      w_next_state = BUF_FULL;
                else if (!push && w_pop) w_next_state = BUF_EMPTY;
            end
            BUF_FULL:  if (w_pop) w_next_state = BUF_ONE;
            default:   w_next_state = BUF_EMPTY;
        endcase
    end

    // With one entry, a simultaneous push/pop replaces the head directly so
    // ordering is kept without touching the skid register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            unique case (r_state)
                BUF_EMPTY: if (push) r_head <= push_data;
                BUF_ONE: begin
                    if (push) begin
                        if (w_pop) r_head <= push_data;
                        else       r_skid <= push_data;
                    end
                end
                BUF_FULL:  if (w_pop) r_head <= r_skid;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/operand_select_reg.sv
// operand_select_reg: registered NUM_IN-way operand selector feeding the vALU.
//   clk, rst_n : clock, async active-low reset
//   arb_mode   : ARB_FIXED uses sel, ARB_RR scans upward from rr_ptr
//   sel        : channel index in fixed mode (>= NUM_IN grants nothing)
//   in_data    : channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready, one-hot or zero, independent of out_ready
//   out_data   : registered selected data
//   out_chan   : channel that supplied out_data
//   out_valid  : output valid
//   out_ready  : downstream ready
module operand_select_reg
    import operand_select_reg_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arb_mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_chan,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [SEL_W-1:0]       r_rr_ptr;
    logic [NUM_IN-1:0]      w_grant;
    logic [SEL_W-1:0]       w_grant_idx;
    logic                   w_found;
    int                     w_scan_idx;
    logic [WIDTH-1:0]       w_sel_data;
    logic                   w_full;
    logic                   w_accept;
    logic [WIDTH+SEL_W-1:0] w_buf_out;

    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_scan_idx  = 0;
        if (arb_mode == ARB_FIXED) begin
            if (int'(sel) < NUM_IN) begin
                w_grant_idx   = sel;
                w_grant[sel]  = in_valid[sel];
            end
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                w_scan_idx = int'(r_rr_ptr) + k;
                if (w_scan_idx >= NUM_IN) w_scan_idx = w_scan_idx - NUM_IN;
                if (!w_found && in_valid[w_scan_idx]) begin
                    w_found             = 1'b1;
                    w_grant[w_scan_idx] = 1'b1;
                    w_grant_idx         = SEL_W'(w_scan_idx);
                end
            end
        end
    end

    // Gated by rst_n so nothing looks accepted while reset is held.
    assign in_ready = w_grant & {NUM_IN{rst_n & ~w_full}};
    assign w_accept = |in_ready;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_sel_data = w_sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_accept && (arb_mode == ARB_RR)) begin
            r_rr_ptr <= (w_grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : w_grant_idx + SEL_W'(1);
        end
    end

    skid_buffer2 #(
        .DW (WIDTH + SEL_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_accept),
        .push_data ({w_sel_data, w_grant_idx}),
        .full      (w_full),
        .pop_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (w_buf_out)
    );

    assign out_data = w_buf_out[WIDTH+SEL_W-1:SEL_W];
    assign out_chan = w_buf_out[SEL_W-1:0];

endmodule

// File: tb/tb_operand_select_reg.sv
module tb_operand_select_reg;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         arb_mode;
    logic [1:0]   sel;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_chan;
    logic         out_valid;
    logic         out_ready;

    logic         arb_mode3;
    logic [1:0]   sel3;
    logic [95:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [31:0]  out_data3;
    logic [1:0]   out_chan3;
    logic         out_valid3;
    logic         out_ready3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    operand_select_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_mode  (arb_mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    operand_select_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_mode  (arb_mode3),
        .sel       (sel3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_chan  (out_chan3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    function automatic logic [31:0] chan_data(input int c);
        case (c)
            0:       return 32'h1111_1111;
            1:       return 32'h2222_2222;
            2:       return 32'hDEAD_BEEF;
            default: return 32'h4444_4444;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        arb_mode   = 1'b0;
        sel        = 2'd0;
        in_valid   = 4'hF;
        out_ready  = 1'b1;
        in_data    = {chan_data(3), chan_data(2), chan_data(1), chan_data(0)};
        arb_mode3  = 1'b0;
        sel3       = 2'd0;
        in_valid3  = 3'b000;
        out_ready3 = 1'b1;
        in_data3   = {32'h0C0C_0C0C, 32'h0B0B_0B0B, 32'h0A0A_0A0A};
        tick();
        tick();
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b expected %b", in_ready, 4'b0000); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
        n_checks++; if (out_chan !== 2'd0) begin n_fail++; $display("FAIL reset_out_chan: got %0d expected 0", out_chan); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL release_in_ready: got %b expected 0001", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_accept_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_data !== 32'h1111_1111) begin n_fail++; $display("FAIL first_accept_data: got %h expected 11111111", out_data); end
        in_valid = 4'h0;
        tick();
        tick();
    endtask

    task automatic test_fixed();
        sel      = 2'd2;
        in_valid = 4'hF;
        #1;
        n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL fixed_in_ready: got %b expected 0100", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fixed_out_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fixed_out_data: got %h expected deadbeef", out_data); end
        n_checks++; if (out_chan !== 2'd2) begin n_fail++; $display("FAIL fixed_out_chan: got %0d expected 2", out_chan); end
        in_valid = 4'h0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fixed_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_chan;
        arb_mode  = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_chan = 2'(i % 4);
            n_checks++; if (out_valid !== 1'b1 || out_chan !== exp_chan) begin n_fail++; $display("FAIL rr_all_%0d: got chan %0d valid %b expected chan %0d valid 1", i, out_chan, out_valid, exp_chan); end
            n_checks++; if (out_data !== chan_data(int'(exp_chan))) begin n_fail++; $display("FAIL rr_all_data_%0d: got %h expected %h", i, out_data, chan_data(int'(exp_chan))); end
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_chan = (i % 2 == 0) ? 2'd1 : 2'd3;
            n_checks++; if (out_valid !== 1'b1 || out_chan !== exp_chan) begin n_fail++; $display("FAIL rr_1010_%0d: got chan %0d valid %b expected chan %0d valid 1", i, out_chan, out_valid, exp_chan); end
        end
        in_valid = 4'h0;
        tick();
        arb_mode = 1'b0;
        tick();
    endtask

    task automatic test_back_pressure();
        sel            = 2'd0;
        out_ready      = 1'b0;
        in_data[31:0]  = 32'hAAAA_0001;
        in_valid       = 4'b0001;
        #1;
        n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_ready_a: got %b expected 0001", in_ready); end
        tick();
        in_data[31:0] = 32'hAAAA_0002;
        #1;
        n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_ready_b: got %b expected 0001", in_ready); end
        n_checks++; if (out_data !== 32'hAAAA_0001) begin n_fail++; $display("FAIL bp_head_a: got %h expected aaaa0001", out_data); end
        tick();
        in_data[31:0] = 32'hAAAA_0003;
        #1;
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_full_ready: got %b expected 0000", in_ready); end
        tick();
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_full_hold_ready: got %b expected 0000", in_ready); end
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hAAAA_0001) begin n_fail++; $display("FAIL bp_hold: got %h valid %b expected aaaa0001 valid 1", out_data, out_valid); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_data !== 32'hAAAA_0002) begin n_fail++; $display("FAIL bp_deliver_b: got %h expected aaaa0002", out_data); end
        n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_slot_freed: got %b expected 0001", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hAAAA_0003) begin n_fail++; $display("FAIL bp_deliver_c: got %h valid %b expected aaaa0003 valid 1", out_data, out_valid); end
        in_valid = 4'h0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || out_data !== 32'hAAAA_0003) begin n_fail++; $display("FAIL bp_empty_hold: got %h valid %b expected aaaa0003 valid 0", out_data, out_valid); end
        in_data[31:0] = chan_data(0);
    endtask

    task automatic test_invalid_sel();
        sel3       = 2'd0;
        in_valid3  = 3'b001;
        out_ready3 = 1'b0;
        #1;
        n_checks++; if (in_ready3 !== 3'b001) begin n_fail++; $display("FAIL inv_pre_ready: got %b expected 001", in_ready3); end
        tick();
        sel3      = 2'd3;
        in_valid3 = 3'b111;
        #1;
        n_checks++; if (in_ready3 !== 3'b000) begin n_fail++; $display("FAIL inv_sel_ready: got %b expected 000", in_ready3); end
        tick();
        n_checks++; if (out_valid3 !== 1'b1 || out_data3 !== 32'h0A0A_0A0A || out_chan3 !== 2'd0) begin n_fail++; $display("FAIL inv_buffer: got %h chan %0d valid %b expected 0a0a0a0a chan 0 valid 1", out_data3, out_chan3, out_valid3); end
        out_ready3 = 1'b1;
        tick();
        n_checks++; if (out_valid3 !== 1'b0) begin n_fail++; $display("FAIL inv_no_push: got %b expected 0", out_valid3); end
        in_valid3 = 3'b000;
    endtask

    task automatic test_mid_reset();
        sel           = 2'd0;
        out_ready     = 1'b0;
        in_data[31:0] = 32'h5555_5555;
        in_valid      = 4'b0001;
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 4'b0000) begin n_fail++; $display("FAIL mr_full: got valid %b ready %b expected valid 1 ready 0000", out_valid, in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_async_drop: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL mr_async_data: got %h expected 00000000", out_data); end
        in_valid  = 4'h0;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_no_stale_%0d: got %b expected 0", i, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_back_pressure();
        test_invalid_sel();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
